bus_mux_reg: RTL and testbench

Parametrised, registered bus multiplexer that drives the processor's shared data bus (BusWires) from NSRC general registers, the DIN input and the G (ALU result) register. It replaces the purely combinational select path with a one-cycle registered stage featuring:
- fixed-priority source resolution and a hold/stall mode;
- sticky detection of conflicting selects;
- a saturating transfer counter.

It sits between the register file/ALU and every bus consumer, and is steered by the control FSM's one-hot select outputs.

---
 rtl/bus_mux_reg_if.sv | 35 +++
 rtl/bus_mux_reg.sv | 98 +++++++++
 tb/tb_bus_mux_reg.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_mux_reg_if.sv
// bus_mux_reg_if: source data, one-hot selects and registered results of the bus multiplexer.
// Latency: none here; pure signal bundle.
// Backpressure: none; Hold is the only stall input and it is driven by the control side.
interface bus_mux_reg_if #(
  parameter int WIDTH = 16,
  parameter int NSRC  = 8
);
  localparam int IDW = $clog2(NSRC + 2);

  logic [NSRC*WIDTH-1:0] RIn;
  logic [WIDTH-1:0]      DIN;
  logic [WIDTH-1:0]      G;
  logic [NSRC-1:0]       Rout;
  logic                  DINout;
  logic                  Gout;
  logic                  Hold;
  logic                  ClrErr;
  logic [WIDTH-1:0]      BusWires;
  logic                  BusValid;
  logic [IDW-1:0]        SrcId;
  logic                  Conflict;
  logic [15:0]           XferCount;

  // Control FSM / register file side: drives sources and selects, observes the bus.
  modport master (
    output RIn, DIN, G, Rout, DINout, Gout, Hold, ClrErr,
    input  BusWires, BusValid, SrcId, Conflict, XferCount
  );

  // Multiplexer side.
  modport slave (
    input  RIn, DIN, G, Rout, DINout, Gout, Hold, ClrErr,
    output BusWires, BusValid, SrcId, Conflict, XferCount
  );
endinterface

// File: rtl/bus_mux_reg.sv
// bus_mux_reg: registered shared-bus mux, priority G > DIN > lowest Rout, sticky conflict, saturating count.
// Latency: 1 cycle from select/data at edge N to BusWires/BusValid/SrcId after edge N.
// Backpressure: Hold freezes bus, id and count and suppresses BusValid; no ready signal back to sources.
module bus_mux_reg #(
  parameter int WIDTH = 16,
  parameter int NSRC  = 8
) (
  input logic          Clock,
  input logic          Resetn,
  bus_mux_reg_if.slave bus
);
  localparam int IDW = $clog2(NSRC + 2);
  localparam logic [IDW-1:0]  DIN_ID   = IDW'(NSRC);
  localparam logic [IDW-1:0]  G_ID     = IDW'(NSRC + 1);
  localparam logic [NSRC-1:0] ROUT_ONE = NSRC'(1);
  localparam logic [15:0]     XFER_MAX = 16'hFFFF;

  logic [WIDTH-1:0] selVal;
  logic [IDW-1:0]   selId;
  logic             anySel;
  logic             multiSel;

  logic [WIDTH-1:0] busReg;
  logic             validReg;
  logic [IDW-1:0]   idReg;
  logic             conflictReg;
  logic [15:0]      countReg;

  // Resolve the winning source: later assignments override earlier ones, so the
  // descending register scan leaves the lowest index, then DIN and G take over.
  always_comb begin
    selVal = '0;
    selId  = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (bus.Rout[i]) begin
        selVal = bus.RIn[i*WIDTH +: WIDTH];
        selId  = IDW'(i);
      end
    end
    if (bus.DINout) begin
      selVal = bus.DIN;
      selId  = DIN_ID;
    end
    if (bus.Gout) begin
      selVal = bus.G;
      selId  = G_ID;
    end
  end

  assign anySel = bus.Gout | bus.DINout | (|bus.Rout);

  // More than one select: any pair among G/DIN/registers, or two register bits
  // (x & (x-1) clears the lowest set bit, leaving nonzero only if another remains).
  assign multiSel = (bus.Gout & bus.DINout)
                  | ((bus.Gout | bus.DINout) & (|bus.Rout))
                  | (|(bus.Rout & (bus.Rout - ROUT_ONE)));

  // Bus stage: capture on a select, keep the last value when idle or held.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      busReg   <= '0;
      idReg    <= '0;
      validReg <= 1'b0;
    end else if (!bus.Hold && anySel) begin
      busReg   <= selVal;
      idReg    <= selId;
      validReg <= 1'b1;
    end else begin
      validReg <= 1'b0;
    end
  end

  // Sticky conflict flag: a new conflict outranks a simultaneous clear; clear also works while held.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      conflictReg <= 1'b0;
    end else if (!bus.Hold && multiSel) begin
      conflictReg <= 1'b1;
    end else if (bus.ClrErr) begin
      conflictReg <= 1'b0;
    end
  end

  // Transfer counter: one per capture, pinned at all-ones until reset.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      countReg <= '0;
    end else if (!bus.Hold && anySel && (countReg != XFER_MAX)) begin
      countReg <= countReg + 16'd1;
    end
  end

  assign bus.BusWires  = busReg;
  assign bus.BusValid  = validReg;
  assign bus.SrcId     = idReg;
  assign bus.Conflict  = conflictReg;
  assign bus.XferCount = countReg;
endmodule

// File: tb/tb_bus_mux_reg.sv
// tb_bus_mux_reg: directed scenarios plus random traffic against a behavioural bus model.
// Latency: model advances once per rising edge; outputs sampled 1 time unit after it.
// Backpressure: Hold exercised directly and randomly.
module tb_bus_mux_reg;
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bus_mux_reg_if #(.WIDTH(16), .NSRC(8)) bi ();
  bus_mux_reg_if #(.WIDTH(8),  .NSRC(1)) bs ();

  bus_mux_reg #(.WIDTH(16), .NSRC(8)) dut      (.Clock(clk), .Resetn(rstn), .bus(bi));
  bus_mux_reg #(.WIDTH(8),  .NSRC(1)) dutSmall (.Clock(clk), .Resetn(rstn), .bus(bs));

  // Behavioural model state for the 16-bit / 8-source instance.
  logic [15:0] mBus;
  logic [3:0]  mId;
  logic        mValid;
  logic        mConf;
  int          mCount;

  task automatic clearInputs();
    bi.RIn = '0; bi.DIN = '0; bi.G = '0; bi.Rout = '0;
    bi.DINout = 1'b0; bi.Gout = 1'b0; bi.Hold = 1'b0; bi.ClrErr = 1'b0;
    bs.RIn = '0; bs.DIN = '0; bs.G = '0; bs.Rout = '0;
    bs.DINout = 1'b0; bs.Gout = 1'b0; bs.Hold = 1'b0; bs.ClrErr = 1'b0;
  endtask

  task automatic modelReset();
    mBus = '0; mId = '0; mValid = 1'b0; mConf = 1'b0; mCount = 0;
  endtask

  // One rising edge of the bus as described behaviourally: count selects,
  // pick the winner by priority, update the sticky flag and the counter.
  task automatic modelEdge();
    int nsel;
    int idx;
    if (bi.Hold) begin
      mValid = 1'b0;
      if (bi.ClrErr) mConf = 1'b0;
    end else begin
      nsel = $countones(bi.Rout) + int'(bi.Gout) + int'(bi.DINout);
      if (nsel == 0) begin
        mValid = 1'b0;
      end else begin
        if (bi.Gout) begin
          mBus = bi.G; mId = 4'd9;
        end else if (bi.DINout) begin
          mBus = bi.DIN; mId = 4'd8;
        end else begin
          idx = 0;
          while (!bi.Rout[idx]) idx++;
          mBus = bi.RIn[idx*16 +: 16];
          mId  = 4'(idx);
        end
        mValid = 1'b1;
        if (mCount < 65535) mCount++;
      end
      if (nsel > 1) mConf = 1'b1;
      else if (bi.ClrErr) mConf = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic doReset();
    rstn = 1'b0;
    clearInputs();
    modelReset();
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    clearInputs();
    modelReset();
    #2;
    vectors += 6;
    if (bi.BusWires !== 16'h0) begin miscompares++; $display("FAIL reset_bus: got %h expected 0000", bi.BusWires); end
    if (bi.BusValid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", bi.BusValid); end
    if (bi.SrcId !== 4'h0) begin miscompares++; $display("FAIL reset_id: got %0d expected 0", bi.SrcId); end
    if (bi.Conflict !== 1'b0) begin miscompares++; $display("FAIL reset_conflict: got %b expected 0", bi.Conflict); end
    if (bi.XferCount !== 16'h0) begin miscompares++; $display("FAIL reset_count: got %h expected 0000", bi.XferCount); end
    if (bs.BusWires !== 8'h0) begin miscompares++; $display("FAIL reset_small_bus: got %h expected 00", bs.BusWires); end
    // Selects during reset must not be captured.
    bi.Gout = 1'b1; bi.G = 16'hFFFF;
    @(posedge clk);
    #1;
    vectors += 2;
    if (bi.BusWires !== 16'h0) begin miscompares++; $display("FAIL reset_hold_bus: got %h expected 0000", bi.BusWires); end
    if (bi.BusValid !== 1'b0) begin miscompares++; $display("FAIL reset_hold_valid: got %b expected 0", bi.BusValid); end
    clearInputs();
    rstn = 1'b1;
  endtask

  task automatic test_reset_midstream();
    bi.RIn[3*16 +: 16] = 16'h1234;
    bi.Rout = 8'h08;
    step();
    vectors += 2;
    if (bi.BusWires !== 16'h1234) begin miscompares++; $display("FAIL mid_capture_bus: got %h expected 1234", bi.BusWires); end
    if (bi.SrcId !== 4'd3) begin miscompares++; $display("FAIL mid_capture_id: got %0d expected 3", bi.SrcId); end
    #2;
    rstn = 1'b0;
    modelReset();
    #1;
    vectors += 4;
    if (bi.BusWires !== 16'h0) begin miscompares++; $display("FAIL mid_reset_bus: got %h expected 0000", bi.BusWires); end
    if (bi.BusValid !== 1'b0) begin miscompares++; $display("FAIL mid_reset_valid: got %b expected 0", bi.BusValid); end
    if (bi.SrcId !== 4'd0) begin miscompares++; $display("FAIL mid_reset_id: got %0d expected 0", bi.SrcId); end
    if (bi.XferCount !== 16'h0) begin miscompares++; $display("FAIL mid_reset_count: got %h expected 0000", bi.XferCount); end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    clearInputs();
    bi.Gout = 1'b1; bi.G = 16'hBEEF;
    step();
    vectors += 4;
    if (bi.BusWires !== 16'hBEEF) begin miscompares++; $display("FAIL post_reset_bus: got %h expected beef", bi.BusWires); end
    if (bi.SrcId !== 4'd9) begin miscompares++; $display("FAIL post_reset_id: got %0d expected 9", bi.SrcId); end
    if (bi.BusValid !== 1'b1) begin miscompares++; $display("FAIL post_reset_valid: got %b expected 1", bi.BusValid); end
    if (bi.XferCount !== 16'd1) begin miscompares++; $display("FAIL post_reset_count: got %0d expected 1", bi.XferCount); end
  endtask

  task automatic test_sweep();
    logic [15:0] want;
    doReset();
    for (int i = 0; i < 8; i++) bi.RIn[i*16 +: 16] = 16'h1000 + 16'(i);
    bi.DIN = 16'h00AA;
    bi.G   = 16'h5555;
    for (int s = 0; s < 10; s++) begin
      bi.Rout = '0; bi.DINout = 1'b0; bi.Gout = 1'b0;
      if (s < 8) bi.Rout[s] = 1'b1;
      else if (s == 8) bi.DINout = 1'b1;
      else bi.Gout = 1'b1;
      step();
      want = (s < 8) ? 16'h1000 + 16'(s) : ((s == 8) ? 16'h00AA : 16'h5555);
      vectors += 3;
      if (bi.BusWires !== want) begin miscompares++; $display("FAIL sweep_bus[%0d]: got %h expected %h", s, bi.BusWires, want); end
      if (bi.SrcId !== 4'(s)) begin miscompares++; $display("FAIL sweep_id[%0d]: got %0d expected %0d", s, bi.SrcId, s); end
      if (bi.BusValid !== 1'b1) begin miscompares++; $display("FAIL sweep_valid[%0d]: got %b expected 1", s, bi.BusValid); end
    end
    vectors++;
    if (bi.XferCount !== 16'd10) begin miscompares++; $display("FAIL sweep_count: got %0d expected 10", bi.XferCount); end
    clearInputs();
  endtask

  task automatic test_conflict();
    bi.G = 16'hC0DE; bi.DIN = 16'h1111;
    bi.RIn[2*16 +: 16] = 16'h2222; bi.RIn[5*16 +: 16] = 16'h5555;
    bi.Gout = 1'b1; bi.DINout = 1'b1; bi.Rout = 8'b0010_0100; bi.ClrErr = 1'b1;
    step();
    vectors += 3;
    if (bi.BusWires !== 16'hC0DE) begin miscompares++; $display("FAIL conflict_bus: got %h expected c0de", bi.BusWires); end
    if (bi.SrcId !== 4'd9) begin miscompares++; $display("FAIL conflict_id: got %0d expected 9", bi.SrcId); end
    if (bi.Conflict !== 1'b1) begin miscompares++; $display("FAIL conflict_set_wins: got %b expected 1", bi.Conflict); end
    clearInputs();
    bi.Rout = 8'b0010_0100;
    bi.RIn[2*16 +: 16] = 16'h2222;
    step();
    vectors += 2;
    if (bi.BusWires !== 16'h2222) begin miscompares++; $display("FAIL conflict_lowest_bus: got %h expected 2222", bi.BusWires); end
    if (bi.Conflict !== 1'b1) begin miscompares++; $display("FAIL conflict_sticky: got %b expected 1", bi.Conflict); end
    clearInputs();
    bi.ClrErr = 1'b1;
    step();
    vectors++;
    if (bi.Conflict !== 1'b0) begin miscompares++; $display("FAIL conflict_clear: got %b expected 0", bi.Conflict); end
    clearInputs();
  endtask

  task automatic test_idle_hold();
    int cnt;
    bi.RIn[5*16 +: 16] = 16'h0F0F;
    bi.Rout = 8'h20;
    step();
    clearInputs();
    step();
    vectors += 3;
    if (bi.BusWires !== 16'h0F0F) begin miscompares++; $display("FAIL idle_bus: got %h expected 0f0f", bi.BusWires); end
    if (bi.BusValid !== 1'b0) begin miscompares++; $display("FAIL idle_valid: got %b expected 0", bi.BusValid); end
    if (bi.SrcId !== 4'd5) begin miscompares++; $display("FAIL idle_id: got %0d expected 5", bi.SrcId); end
    cnt = mCount;
    bi.Hold = 1'b1; bi.Rout = 8'h01; bi.DINout = 1'b1; bi.DIN = 16'hDEAD;
    step();
    vectors += 4;
    if (bi.BusWires !== 16'h0F0F) begin miscompares++; $display("FAIL hold_bus: got %h expected 0f0f", bi.BusWires); end
    if (bi.BusValid !== 1'b0) begin miscompares++; $display("FAIL hold_valid: got %b expected 0", bi.BusValid); end
    if (bi.Conflict !== 1'b0) begin miscompares++; $display("FAIL hold_conflict: got %b expected 0", bi.Conflict); end
    if (bi.XferCount !== 16'(cnt)) begin miscompares++; $display("FAIL hold_count: got %0d expected %0d", bi.XferCount, cnt); end
    // Release Hold with the select still present: captures on that very edge.
    bi.Hold = 1'b0; bi.DINout = 1'b0;
    bi.RIn[0 +: 16] = 16'hABCD;
    step();
    vectors += 2;
    if (bi.BusWires !== 16'hABCD) begin miscompares++; $display("FAIL unhold_bus: got %h expected abcd", bi.BusWires); end
    if (bi.XferCount !== 16'(cnt + 1)) begin miscompares++; $display("FAIL unhold_count: got %0d expected %0d", bi.XferCount, cnt + 1); end
    clearInputs();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      bi.Hold   = ($urandom_range(0, 4) == 0);
      bi.ClrErr = ($urandom_range(0, 7) == 0);
      bi.Gout   = ($urandom_range(0, 5) == 0);
      bi.DINout = ($urandom_range(0, 5) == 0);
      bi.Rout   = 8'($urandom) & 8'($urandom) & 8'($urandom);
      bi.DIN    = 16'($urandom);
      bi.G      = 16'($urandom);
      for (int i = 0; i < 8; i++) bi.RIn[i*16 +: 16] = 16'($urandom);
      #1;
      vectors++;
      if (bi.BusWires !== mBus) begin miscompares++; $display("FAIL rand_between_edges[%0d]: got %h expected %h", n, bi.BusWires, mBus); end
      step();
      vectors += 5;
      if (bi.BusWires !== mBus) begin miscompares++; $display("FAIL rand_bus[%0d]: got %h expected %h", n, bi.BusWires, mBus); end
      if (bi.SrcId !== mId) begin miscompares++; $display("FAIL rand_id[%0d]: got %0d expected %0d", n, bi.SrcId, mId); end
      if (bi.BusValid !== mValid) begin miscompares++; $display("FAIL rand_valid[%0d]: got %b expected %b", n, bi.BusValid, mValid); end
      if (bi.Conflict !== mConf) begin miscompares++; $display("FAIL rand_conflict[%0d]: got %b expected %b", n, bi.Conflict, mConf); end
      if (bi.XferCount !== 16'(mCount)) begin miscompares++; $display("FAIL rand_count[%0d]: got %0d expected %0d", n, bi.XferCount, mCount); end
    end
    clearInputs();
  endtask

  task automatic test_saturation();
    doReset();
    bi.Gout = 1'b1; bi.G = 16'h7777;
    repeat (65534) step();
    vectors++;
    if (bi.XferCount !== 16'hFFFE) begin miscompares++; $display("FAIL sat_before: got %h expected fffe", bi.XferCount); end
    step();
    vectors++;
    if (bi.XferCount !== 16'hFFFF) begin miscompares++; $display("FAIL sat_reach: got %h expected ffff", bi.XferCount); end
    for (int k = 0; k < 5; k++) begin
      step();
      vectors += 2;
      if (bi.XferCount !== 16'hFFFF) begin miscompares++; $display("FAIL sat_stuck[%0d]: got %h expected ffff", k, bi.XferCount); end
      if (bi.BusValid !== 1'b1) begin miscompares++; $display("FAIL sat_valid[%0d]: got %b expected 1", k, bi.BusValid); end
    end
    clearInputs();
  endtask

  task automatic test_small_params();
    doReset();
    bs.RIn = 8'hA5; bs.DIN = 8'h3C; bs.G = 8'hC3;
    bs.Rout = 1'b1;
    step();
    vectors += 2;
    if (bs.BusWires !== 8'hA5) begin miscompares++; $display("FAIL small_r0_bus: got %h expected a5", bs.BusWires); end
    if (bs.SrcId !== 2'd0) begin miscompares++; $display("FAIL small_r0_id: got %0d expected 0", bs.SrcId); end
    bs.Rout = 1'b0; bs.DINout = 1'b1;
    step();
    vectors += 2;
    if (bs.BusWires !== 8'h3C) begin miscompares++; $display("FAIL small_din_bus: got %h expected 3c", bs.BusWires); end
    if (bs.SrcId !== 2'd1) begin miscompares++; $display("FAIL small_din_id: got %0d expected 1", bs.SrcId); end
    bs.DINout = 1'b0; bs.Gout = 1'b1;
    step();
    vectors += 3;
    if (bs.BusWires !== 8'hC3) begin miscompares++; $display("FAIL small_g_bus: got %h expected c3", bs.BusWires); end
    if (bs.SrcId !== 2'd2) begin miscompares++; $display("FAIL small_g_id: got %0d expected 2", bs.SrcId); end
    if (bs.XferCount !== 16'd3) begin miscompares++; $display("FAIL small_count: got %0d expected 3", bs.XferCount); end
    bs.Rout = 1'b1; bs.DINout = 1'b1;
    step();
    vectors += 2;
    if (bs.SrcId !== 2'd2) begin miscompares++; $display("FAIL small_prio_id: got %0d expected 2", bs.SrcId); end
    if (bs.Conflict !== 1'b1) begin miscompares++; $display("FAIL small_conflict: got %b expected 1", bs.Conflict); end
    clearInputs();
  endtask

  initial begin
    test_reset();
    test_reset_midstream();
    test_sweep();
    test_conflict();
    test_idle_hold();
    test_random();
    test_saturation();
    test_small_params();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
